fwd_scoreboard: RTL and testbench
=================================

# fwd_scoreboard

Parametrised forwarding and load-use hazard unit sitting beside the ID stage of the pipeline. It keeps its own registered scoreboard of in-flight destination registers for every stage between ID and write-back. For each ID source operand it produces a one-hot-free stage select for the operand mux. It raises a stall when the youngest matching producer has not yet produced its data. It is opcode-agnostic: decode supplies per-instruction write/load flags, so any number of source ports and pipeline depths is supported.

## Interface
- NUM_SRC, 2: number of ID source operands checked (rs1, rs2, …).
- NUM_STAGES, 3: in-flight stages tracked after ID (stage 0 = EX, 1 = M, 2 = RB).
- LOAD_READY_STAGE, 1: first stage index at which load data is forwardable.
- CNT_W, 32: width of stall performance counter.
- SELW (derived, not overridable): $clog2(NUM_STAGES+1).

- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rd  in  5  destination of ID instruction.
- id_wen  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- id_src_addr  in  NUM_SRC*5  source register numbers, source i at [5i+4:5i].
- id_src_used  in  NUM_SRC  source i is actually read.
- flush  in  1  ID instruction is killed (taken branch/jump).
- hold  in  1  global freeze (memory wait); scoreboard does not advance.
- fwd_sel  out  NUM_SRC*SELW  per source: 0 = register file, k+1 = stage k result.
- stall  out  1  hold IF/ID, inject bubble into EX.
- stall_cnt  out  CNT_W  cycles in which stall was asserted and hold was low, saturating.

## Operation
- Each stage entry: {valid, rd, wen, is_load}. An entry is a producer iff valid & wen & rd != 0.
- Source i matches stage k iff id_src_used[i] & id_valid & producer(k) & rd(k) == src_addr(i).
- fwd_sel[i] = k+1 for the smallest matching k (youngest producer wins), else 0. Register x0 never forwards.
- Ready(k) = !is_load(k) | k >= LOAD_READY_STAGE.
- stall = OR over i of (youngest match for i exists and not Ready). When stall is high, fwd_sel values are don't-care for the consumer but remain computed as above.
- Advance (hold low), on each clk edge:
  - Stage k+1 takes stage k.
  - Stage 0 takes the ID instruction if id_valid & !stall & !flush, else a bubble (valid=0).
  - The last stage's entry is discarded.
- hold high: all entries and stall_cnt keep their value. Outputs remain combinationally valid.
- stall and flush together: flush dominates, bubble enters stage 0, and stall_cnt still increments.
- stall_cnt increments when stall & !hold, and saturates at all ones.

## Timing
- fwd_sel and stall are purely combinational from the registered scoreboard and ID inputs, with zero-cycle latency. No combinational path from stall back into the scoreboard inputs other than the stage-0 load enable.
- Scoreboard updates on posedge clk.
- Reset (any time, including mid-stall) clears every valid bit and stall_cnt to 0. Immediately after reset, fwd_sel = 0 and stall = 0.
- Load-use with default parameters: a load in EX and a dependent in ID gives exactly 1 stall cycle. The next cycle the load is in M and fwd_sel = 2.
- Producers at stage index >= LOAD_READY_STAGE never stall.
- Write-back stage is forwarded (fwd_sel = NUM_STAGES), so the register file needs no write-through.

## Structure
- Def.v gains the `define constants FWD_SEL_RF (0) and stage index names EX/M/RB (0/1/2).
- Sub-module fwd_src_select, instantiated NUM_SRC times:
  - Inputs: one source address, its used bit, and the flattened scoreboard.
  - Outputs: priority-encoded select and a per-source stall request.
- Top level holds the scoreboard shift registers, the stall OR, and the counter.

## Test plan
- Reset then idle: rst pulse mid-traffic. Expect all fwd_sel = 0, stall = 0, stall_cnt = 0 immediately and after release.
- ALU chain: add x5 issued, then an ID instruction reading x5 as src0. Expect fwd_sel[0] = 1 with no stall; one cycle later with a bubble between, fwd_sel[0] = 2; after two bubbles, fwd_sel[0] = 3.
- Youngest wins: x7 written in stage 2 and stage 0, ID reads x7 on both sources. Expect fwd_sel = {1,1}.
- Load-use:
  - lw x3 issued, then ID reads x3 on src1. Expect stall = 1 for one cycle and a bubble in EX.
  - Next cycle stall = 0, fwd_sel[1] = 2, stall_cnt = 1.
- x0 and unused: producer writes x0 and ID reads x0. Expect fwd_sel = 0. A matching x4 with id_src_used = 0 also gives 0 and no stall.
- Hold/flush/saturation:
  - hold = 1 for 3 cycles during a load-use. Scoreboard and stall_cnt are frozen.
  - flush with stall: stage 0 becomes a bubble and the counter still increments.
  - With CNT_W = 4 and 20 stall cycles, stall_cnt = 15.

Source files
------------

// File: rtl/fwd_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_scoreboard_pkg
// Description : Shared types, constants and helpers for the forwarding /
//               load-use hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package fwd_scoreboard_pkg;

  // Architectural register number width
  localparam int c_REG_W = 5;

  // Operand mux select value meaning "take the register file"
  localparam int c_FWD_SEL_RF = 0;

  // Stage index names for the default three-stage tracking window
  typedef enum logic [1:0] {
    STG_EX = 2'd0,
    STG_M  = 2'd1,
    STG_RB = 2'd2
  } stage_e;

  // One in-flight instruction as seen by the scoreboard
  typedef struct packed {
    logic               valid;
    logic [c_REG_W-1:0] rd;
    logic               wen;
    logic               is_load;
  } sb_entry_t;

  localparam int c_ENTRY_W = $bits(sb_entry_t);

  // An entry produces a value only if it is real, writes, and is not x0
  function automatic logic is_producer(input sb_entry_t e);
    return e.valid & e.wen & (e.rd != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : fwd_scoreboard_if
// Description : ID-side bundle between decode and the hazard scoreboard.
//               master = decode/ID stage, slave = scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
interface fwd_scoreboard_if #(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3,
  parameter int CNT_W      = 32
);
  localparam int SELW = $clog2(NUM_STAGES + 1);

  logic                    id_valid;
  logic [4:0]              id_rd;
  logic                    id_wen;
  logic                    id_is_load;
  logic [NUM_SRC*5-1:0]    id_src_addr;
  logic [NUM_SRC-1:0]      id_src_used;
  logic                    flush;
  logic                    hold;
  logic [NUM_SRC*SELW-1:0] fwd_sel;
  logic                    stall;
  logic [CNT_W-1:0]        stall_cnt;

  modport master (
    output id_valid, id_rd, id_wen, id_is_load, id_src_addr, id_src_used,
           flush, hold,
    input  fwd_sel, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_rd, id_wen, id_is_load, id_src_addr, id_src_used,
           flush, hold,
    output fwd_sel, stall, stall_cnt
  );

endinterface
`default_nettype wire

// File: rtl/fwd_scoreboard_src_select.sv
`default_nettype none
// ============================================================================
// Module      : fwd_src_select
// Description : Per-source priority encoder. Picks the youngest in-flight
//               producer of the source register and flags a stall when that
//               producer is a load whose data is not yet forwardable.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_src_select
  import fwd_scoreboard_pkg::*;
#(
  parameter int NUM_STAGES       = 3,
  parameter int LOAD_READY_STAGE = 1,
  parameter int SELW             = 2
) (
  input  logic [4:0]                      src_addr,
  input  logic                            src_used,
  input  logic [NUM_STAGES*c_ENTRY_W-1:0] sb_flat,
  output logic [SELW-1:0]                 sel,
  output logic                            stall_req
);

  sb_entry_t w_sb [NUM_STAGES];

  generate
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_unpack
      assign w_sb[k] = sb_flat[k*c_ENTRY_W +: c_ENTRY_W];
    end
  endgenerate

  // Scan oldest to youngest so the youngest match overwrites older ones
  always_comb begin
    sel       = SELW'(c_FWD_SEL_RF);
    stall_req = 1'b0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (src_used && is_producer(w_sb[k]) && (w_sb[k].rd == src_addr)) begin
        sel       = SELW'(k + 1);
        stall_req = w_sb[k].is_load && (k < LOAD_READY_STAGE);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : fwd_scoreboard
// Description : Forwarding and load-use hazard unit beside ID. Tracks the
//               destinations of every stage after ID, drives per-source
//               operand mux selects, raises stall and counts stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int NUM_SRC          = 2,
  parameter int NUM_STAGES       = 3,
  parameter int LOAD_READY_STAGE = 1,
  parameter int CNT_W            = 32
) (
  input logic              clk,
  input logic              rst,
  fwd_scoreboard_if.slave  bus
);

  localparam int SELW = $clog2(NUM_STAGES + 1);

  sb_entry_t                       r_sb [NUM_STAGES];
  logic [CNT_W-1:0]                r_stall_cnt;
  logic [NUM_STAGES*c_ENTRY_W-1:0] w_sb_flat;
  logic [NUM_SRC*SELW-1:0]         w_fwd_sel;
  logic [NUM_SRC-1:0]              w_stall_req;
  logic                            w_stall;
  logic                            w_issue;
  sb_entry_t                       w_id_entry;

  generate
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_flat
      assign w_sb_flat[k*c_ENTRY_W +: c_ENTRY_W] = r_sb[k];
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_select #(
        .NUM_STAGES       (NUM_STAGES),
        .LOAD_READY_STAGE (LOAD_READY_STAGE),
        .SELW             (SELW)
      ) u_sel (
        .src_addr  (bus.id_src_addr[i*5 +: 5]),
        .src_used  (bus.id_src_used[i] & bus.id_valid),
        .sb_flat   (w_sb_flat),
        .sel       (w_fwd_sel[i*SELW +: SELW]),
        .stall_req (w_stall_req[i])
      );
    end
  endgenerate

  assign w_stall = |w_stall_req;

  // Stall is the only combinational feedback into the scoreboard: it turns
  // the incoming ID instruction into a bubble, as does flush.
  assign w_issue    = bus.id_valid & ~w_stall & ~bus.flush;
  assign w_id_entry = '{valid: w_issue, rd: bus.id_rd, wen: bus.id_wen,
                        is_load: bus.id_is_load};

  // Shift the in-flight window one stage per unfrozen cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_sb[k] <= '0;
      end
    end else if (!bus.hold) begin
      r_sb[0] <= w_id_entry;
      for (int k = 1; k < NUM_STAGES; k++) begin
        r_sb[k] <= r_sb[k-1];
      end
    end
  end

  // Saturating count of cycles that really cost a stall (not frozen)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !bus.hold && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.fwd_sel   = w_fwd_sel;
  assign bus.stall     = w_stall;
  assign bus.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_scoreboard
// Description : Directed self-checking bench for fwd_scoreboard. A second
//               instance with a 4-bit counter covers saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_scoreboard;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_checks;
  int   exp_cnt;

  fwd_scoreboard_if #(.NUM_SRC(2), .NUM_STAGES(3), .CNT_W(32)) bus ();
  fwd_scoreboard_if #(.NUM_SRC(2), .NUM_STAGES(3), .CNT_W(4))  sif ();

  fwd_scoreboard #(
    .NUM_SRC(2), .NUM_STAGES(3), .LOAD_READY_STAGE(1), .CNT_W(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fwd_scoreboard #(
    .NUM_SRC(2), .NUM_STAGES(3), .LOAD_READY_STAGE(1), .CNT_W(4)
  ) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic wen,
                       input logic ld, input logic [4:0] s0,
                       input logic [4:0] s1, input logic [1:0] used);
    bus.id_valid    = v;
    bus.id_rd       = rd;
    bus.id_wen      = wen;
    bus.id_is_load  = ld;
    bus.id_src_addr = {s1, s0};
    bus.id_src_used = used;
  endtask

  task automatic sdrive(input logic v, input logic [4:0] rd, input logic wen,
                        input logic ld, input logic [4:0] s0,
                        input logic [1:0] used);
    sif.id_valid    = v;
    sif.id_rd       = rd;
    sif.id_wen      = wen;
    sif.id_is_load  = ld;
    sif.id_src_addr = {5'd0, s0};
    sif.id_src_used = used;
  endtask

  task automatic drain();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    drive(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd3, 2'b10);
    #1;
    n_checks++;
    if (bus.stall !== 1'b1) $display("FAIL reset_pre_stall got=%b exp=1", bus.stall);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.fwd_sel !== 4'b0000) $display("FAIL reset_fwd got=%b exp=0000", bus.fwd_sel);
    else n_pass++;
    n_checks++;
    if (bus.stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", bus.stall);
    else n_pass++;
    n_checks++;
    if (bus.stall_cnt !== 32'd0) $display("FAIL reset_cnt got=%0d exp=0", bus.stall_cnt);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.fwd_sel !== 4'b0000 || bus.stall !== 1'b0)
      $display("FAIL reset_release got=%b/%b exp=0000/0", bus.fwd_sel, bus.stall);
    else n_pass++;
    n_checks++;
    if (bus.stall_cnt !== 32'd0) $display("FAIL reset_release_cnt got=%0d exp=0", bus.stall_cnt);
    else n_pass++;
    exp_cnt = 0;
    drain();
  endtask

  task automatic test_alu_chain();
    logic [3:0] exp_sel [4];
    exp_sel[0] = 4'b0001;
    exp_sel[1] = 4'b0010;
    exp_sel[2] = 4'b0011;
    exp_sel[3] = 4'b0000;
    drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 2'b01);
      #1;
      n_checks++;
      if (bus.fwd_sel !== exp_sel[i] || bus.stall !== 1'b0)
        $display("FAIL alu_chain_%0d got=%b/%b exp=%b/0", i, bus.fwd_sel, bus.stall, exp_sel[i]);
      else n_pass++;
      drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
      tick();
    end
  endtask

  task automatic test_youngest();
    drain();
    drive(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 5'd7, 2'b11);
    #1;
    n_checks++;
    if (bus.fwd_sel !== 4'b0101 || bus.stall !== 1'b0)
      $display("FAIL youngest_x7 got=%b/%b exp=0101/0", bus.fwd_sel, bus.stall);
    else n_pass++;
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd1, 5'd7, 2'b11);
    #1;
    n_checks++;
    if (bus.fwd_sel !== 4'b0110)
      $display("FAIL youngest_mixed got=%b exp=0110", bus.fwd_sel);
    else n_pass++;
  endtask

  task automatic test_load_use();
    drain();
    drive(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 5'd3, 2'b10);
    #1;
    n_checks++;
    if (bus.stall !== 1'b1 || bus.fwd_sel !== 4'b0100)
      $display("FAIL load_use_stall got=%b/%b exp=1/0100", bus.stall, bus.fwd_sel);
    else n_pass++;
    tick();
    exp_cnt++;
    n_checks++;
    if (bus.stall !== 1'b0 || bus.fwd_sel !== 4'b1000)
      $display("FAIL load_use_next got=%b/%b exp=0/1000", bus.stall, bus.fwd_sel);
    else n_pass++;
    n_checks++;
    if (bus.stall_cnt !== 32'(exp_cnt))
      $display("FAIL load_use_cnt got=%0d exp=%0d", bus.stall_cnt, exp_cnt);
    else n_pass++;
    // The stalled x8 writer must not have entered EX
    drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd8, 5'd3, 2'b11);
    #1;
    n_checks++;
    if (bus.fwd_sel !== 4'b1000)
      $display("FAIL load_use_bubble got=%b exp=1000", bus.fwd_sel);
    else n_pass++;
    tick();
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd8, 5'd0, 2'b01);
    #1;
    n_checks++;
    if (bus.fwd_sel !== 4'b0001 || bus.stall !== 1'b0)
      $display("FAIL load_use_reissue got=%b/%b exp=0001/0", bus.fwd_sel, bus.stall);
    else n_pass++;
  endtask

  task automatic test_x0_unused();
    drain();
    drive(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b11);
    #1;
    n_checks++;
    if (bus.fwd_sel !== 4'b0000 || bus.stall !== 1'b0)
      $display("FAIL x0_read got=%b/%b exp=0000/0", bus.fwd_sel, bus.stall);
    else n_pass++;
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd4, 5'd4, 2'b00);
    #1;
    n_checks++;
    if (bus.fwd_sel !== 4'b0000 || bus.stall !== 1'b0)
      $display("FAIL unused_src got=%b/%b exp=0000/0", bus.fwd_sel, bus.stall);
    else n_pass++;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd4, 5'd0, 2'b01);
    #1;
    n_checks++;
    if (bus.fwd_sel !== 4'b0000 || bus.stall !== 1'b0)
      $display("FAIL invalid_id got=%b/%b exp=0000/0", bus.fwd_sel, bus.stall);
    else n_pass++;
  endtask

  task automatic test_hold();
    drain();
    drive(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 5'd0, 2'b01);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.stall !== 1'b1 || bus.fwd_sel !== 4'b0001 || bus.stall_cnt !== 32'(exp_cnt))
        $display("FAIL hold_%0d got=%b/%b/%0d exp=1/0001/%0d",
                 i, bus.stall, bus.fwd_sel, bus.stall_cnt, exp_cnt);
      else n_pass++;
    end
    bus.hold = 1'b0;
    tick();
    exp_cnt++;
    n_checks++;
    if (bus.stall !== 1'b0 || bus.fwd_sel !== 4'b0010 || bus.stall_cnt !== 32'(exp_cnt))
      $display("FAIL hold_release got=%b/%b/%0d exp=0/0010/%0d",
               bus.stall, bus.fwd_sel, bus.stall_cnt, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_flush();
    drain();
    drive(1'b1, 5'd6, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd6, 5'd0, 2'b01);
    bus.flush = 1'b1;
    #1;
    n_checks++;
    if (bus.stall !== 1'b1) $display("FAIL flush_stall got=%b exp=1", bus.stall);
    else n_pass++;
    tick();
    exp_cnt++;
    bus.flush = 1'b0;
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd6, 5'd9, 2'b11);
    #1;
    n_checks++;
    if (bus.fwd_sel !== 4'b0010 || bus.stall !== 1'b0 || bus.stall_cnt !== 32'(exp_cnt))
      $display("FAIL flush_stall_after got=%b/%b/%0d exp=0010/0/%0d",
               bus.fwd_sel, bus.stall, bus.stall_cnt, exp_cnt);
    else n_pass++;
    drive(1'b1, 5'd10, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd10, 5'd0, 2'b01);
    #1;
    n_checks++;
    if (bus.fwd_sel !== 4'b0000)
      $display("FAIL flush_only got=%b exp=0000", bus.fwd_sel);
    else n_pass++;
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 20; i++) begin
      sdrive(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 2'b00);
      tick();
      sdrive(1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 2'b01);
      #1;
      if (i == 1) begin
        n_checks++;
        if (sif.stall !== 1'b1) $display("FAIL sat_stall got=%b exp=1", sif.stall);
        else n_pass++;
      end
      tick();
      if (i == 14 || i == 15 || i == 20) begin
        n_checks++;
        if (sif.stall_cnt !== ((i < 15) ? 4'(i) : 4'd15))
          $display("FAIL sat_cnt_%0d got=%0d exp=%0d", i, sif.stall_cnt,
                   (i < 15) ? i : 15);
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_pass   = 0;
    n_checks = 0;
    exp_cnt  = 0;
    rst      = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
    sdrive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00);
    sif.flush = 1'b0;
    sif.hold  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    test_reset();
    test_alu_chain();
    test_youngest();
    test_load_use();
    test_x0_unused();
    test_hold();
    test_flush();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
